// File: rtl/bpu_upd_arbiter_pkg.sv
// Shared types for the branch-resolution update arbiter: the queued update record
// and the arbiter FSM state encoding.
package bpu_upd_arbiter_pkg;

   localparam int BPU_HLEN = 4;

   typedef struct packed {
      logic                taken;
      logic [BPU_HLEN-1:0] hist;
   } bpu_upd_t;

   typedef enum logic {ARB_RUN, ARB_FLUSH} bpu_arb_state_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// Small synchronous FIFO of pending gshare updates with push, pop, clear and occupancy.
// The head is read combinationally so an entry written at edge t is visible in cycle t+1.
module bpu_upd_fifo
   import bpu_upd_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  bpu_upd_t                 push_data_i,
   input  logic                     pop_i,
   output bpu_upd_t                 head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   bpu_upd_t          mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Depth is a power of two, so pointer overflow is the modulo wrap.
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push_i && !pop_i)      count_d = count_q + CW'(1);
         else if (!push_i && pop_i) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/bpu_upd_arbiter.sv
// Round-robin arbiter sharing the single gshare update port among N_REQ branch units.
// Accepted resolutions queue in a FIFO whose head is drained to gshare every cycle.
module bpu_upd_arbiter
   import bpu_upd_arbiter_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int HLEN       = BPU_HLEN,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic [N_REQ-1:0]              req_valid_i,
   output logic [N_REQ-1:0]              req_ready_o,
   input  logic [N_REQ-1:0]              req_taken_i,
   input  logic [N_REQ-1:0][HLEN-1:0]    req_hist_i,
   output logic                          upd_valid_o,
   output logic                          upd_taken_o,
   output logic [HLEN-1:0]               upd_hist_o,
   output logic [$clog2(FIFO_DEPTH):0]   pending_o
);

   localparam int IDXW = $clog2(N_REQ);
   localparam int CW   = $clog2(FIFO_DEPTH) + 1;

   bpu_arb_state_t   state_q, state_d;
   logic [IDXW-1:0]  rr_q, rr_d;
   logic [IDXW-1:0]  grant_idx;
   logic             grant_any;
   logic             accept_ok;
   logic             push, pop;
   bpu_upd_t         push_data, head;
   logic [CW-1:0]    count;
   int               idx;

   // First valid requester strictly after the last one served.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(rr_q) + k) % N_REQ;
         if (!grant_any && req_valid_i[idx]) begin
            grant_any = 1'b1;
            grant_idx = IDXW'(idx);
         end
      end
   end

   // A pop in the same cycle never frees space for a push: the check uses current occupancy.
   assign accept_ok = (state_q == ARB_RUN) && !flush_i && (count != CW'(FIFO_DEPTH));

   always_comb begin
      req_ready_o = '0;
      if (accept_ok && grant_any) req_ready_o[grant_idx] = 1'b1;
   end

   assign push            = accept_ok && grant_any;
   assign push_data.taken = req_taken_i[grant_idx];
   assign push_data.hist  = req_hist_i[grant_idx];
   assign rr_d            = push ? grant_idx : rr_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_RUN:   if (flush_i) state_d = ARB_FLUSH;
         ARB_FLUSH: if (!flush_i) state_d = ARB_RUN;
         default:   state_d = ARB_RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ARB_RUN;
         rr_q    <= IDXW'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   // gshare consumes every cycle, so a visible head is always popped.
   assign pop = (count != '0) && (state_q == ARB_RUN) && !flush_i;

   bpu_upd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (flush_i),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count)
   );

   assign upd_valid_o = pop;
   assign upd_taken_o = pop & head.taken;
   assign upd_hist_o  = pop ? head.hist : '0;
   assign pending_o   = count;

endmodule

// File: tb/tb_bpu_upd_arbiter.sv
// Directed self-checking bench for bpu_upd_arbiter (N_REQ=2, HLEN=4, FIFO_DEPTH=4).
module tb_bpu_upd_arbiter;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_taken;
   logic [1:0][3:0]  req_hist;
   logic             upd_valid;
   logic             upd_taken;
   logic [3:0]       upd_hist;
   logic [2:0]       pending;

   int n_checks = 0;
   int n_fails  = 0;

   bpu_upd_arbiter #(
      .N_REQ      (2),
      .HLEN       (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_taken_i (req_taken),
      .req_hist_i  (req_hist),
      .upd_valid_o (upd_valid),
      .upd_taken_o (upd_taken),
      .upd_hist_o  (upd_hist),
      .pending_o   (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = 2'b00;
      req_taken = 2'b01;          // requester 0 taken=1, requester 1 taken=0
      req_hist[0] = 4'h3;
      req_hist[1] = 4'hA;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1. reset then idle
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("idle_pending", 32'(pending), 32'd0);
         chk("idle_upd_valid", 32'(upd_valid), 32'd0);
         chk("idle_ready", 32'(req_ready), 32'd0);
         $display("idle cycle %0d: pending=%0d upd_valid=%0b ready=%b", c, pending, upd_valid, req_ready);
      end

      // 2. contention, two rounds; each requester drops valid once granted
      for (int r = 0; r < 2; r++) begin
         req_valid = 2'b11;
         #1;
         chk("cont_grant0", 32'(req_ready), 32'h1);
         chk("cont_pend0", 32'(pending), 32'd0);
         tick();
         req_valid = 2'b10;
         #1;
         chk("cont_grant1", 32'(req_ready), 32'h2);
         chk("cont_pend1", 32'(pending), 32'd1);
         chk("cont_uv1", 32'(upd_valid), 32'd1);
         chk("cont_ut1", 32'(upd_taken), 32'd1);
         chk("cont_uh1", 32'(upd_hist), 32'h3);
         tick();
         req_valid = 2'b00;
         #1;
         chk("cont_ready_idle", 32'(req_ready), 32'h0);
         chk("cont_uv2", 32'(upd_valid), 32'd1);
         chk("cont_ut2", 32'(upd_taken), 32'd0);
         chk("cont_uh2", 32'(upd_hist), 32'hA);
         tick();
         chk("cont_drained", 32'(pending), 32'd0);
         chk("cont_uv3", 32'(upd_valid), 32'd0);
         chk("cont_uh3", 32'(upd_hist), 32'h0);
         $display("contention round %0d: updates (1,3) then (0,A)", r);
      end

      // 3. continuous back-to-back requests with continuous drain
      for (int k = 0; k < 6; k++) begin
         req_valid = 2'b11;
         #1;
         chk("b2b_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
         chk("b2b_pending", 32'(pending), (k == 0) ? 32'd0 : 32'd1);
         if (k > 0) begin
            chk("b2b_uv", 32'(upd_valid), 32'd1);
            chk("b2b_ut", 32'(upd_taken), ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
            chk("b2b_uh", 32'(upd_hist), ((k - 1) % 2 == 0) ? 32'h3 : 32'hA);
         end
         $display("b2b cycle %0d: ready=%b pending=%0d upd=(%0b,%h)", k, req_ready, pending, upd_taken, upd_hist);
         tick();
      end
      req_valid = 2'b00;
      #1;
      chk("b2b_tail_pend", 32'(pending), 32'd1);
      chk("b2b_tail_uh", 32'(upd_hist), 32'hA);
      tick();
      chk("b2b_empty", 32'(pending), 32'd0);

      // 4. flush held two cycles while requester 1 waits
      req_valid = 2'b01;
      #1;
      chk("fl_pre_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b10;
      flush     = 1'b1;
      #1;
      chk("fl_same_ready", 32'(req_ready), 32'h0);
      chk("fl_same_uv", 32'(upd_valid), 32'd0);
      chk("fl_same_pend", 32'(pending), 32'd1);
      tick();
      chk("fl_st1_pend", 32'(pending), 32'd0);
      chk("fl_st1_ready", 32'(req_ready), 32'h0);
      chk("fl_st1_uv", 32'(upd_valid), 32'd0);
      tick();
      flush = 1'b0;
      #1;
      chk("fl_st2_ready", 32'(req_ready), 32'h0);
      chk("fl_st2_pend", 32'(pending), 32'd0);
      chk("fl_st2_uv", 32'(upd_valid), 32'd0);
      tick();
      chk("fl_run_grant", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      #1;
      chk("fl_post_pend", 32'(pending), 32'd1);
      chk("fl_post_uv", 32'(upd_valid), 32'd1);
      chk("fl_post_uh", 32'(upd_hist), 32'hA);
      $display("flush: pending cleared, requester 1 served after FLUSH");
      tick();
      chk("fl_empty", 32'(pending), 32'd0);

      // 5. fairness: requester 0 always valid, requester 1 from cycle 3
      for (int c = 0; c < 8; c++) begin
         req_valid = (c < 3) ? 2'b01 : 2'b11;
         #1;
         chk("fair_ready", 32'(req_ready),
             (c < 3) ? 32'h1 : (((c - 3) % 2 == 0) ? 32'h2 : 32'h1));
         $display("fair cycle %0d: valid=%b ready=%b", c, req_valid, req_ready);
         tick();
      end
      req_valid = 2'b00;
      #1;
      chk("fair_tail_pend", 32'(pending), 32'd1);
      tick();
      chk("fair_empty", 32'(pending), 32'd0);

      // 6. asynchronous reset mid-drain
      req_valid = 2'b01;
      #1;
      chk("ar_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      #1;
      chk("ar_pre_uv", 32'(upd_valid), 32'd1);
      chk("ar_pre_pend", 32'(pending), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("ar_uv", 32'(upd_valid), 32'd0);
      chk("ar_pend", 32'(pending), 32'd0);
      chk("ar_ut", 32'(upd_taken), 32'd0);
      chk("ar_uh", 32'(upd_hist), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 2'b11;
      #1;
      chk("ar_rr_reset", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      #1;
      chk("ar_post_pend", 32'(pending), 32'd1);
      chk("ar_post_uh", 32'(upd_hist), 32'h3);
      tick();
      chk("ar_empty", 32'(pending), 32'd0);
      $display("async reset: outputs cleared immediately, requester 0 first again");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
